bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per cycle.
// Results at or above 10000 display 9999 and raise overflow.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          digit_1,
  output logic [3:0]          digit_2,
  output logic [3:0]          digit_3,
  output logic [3:0]          digit_4
);

  localparam int unsigned CntW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [IN_WIDTH-1:0] r_opnd;
  logic [15:0]         r_acc;
  logic [CntW-1:0]     r_cnt;
  logic                r_ovf_flag;
  logic [15:0]         r_digits;
  logic                r_overflow;

  logic                w_accept;
  logic                w_last;
  logic [15:0]         w_acc_adj;
  logic [15:0]         w_acc_shift;

  assign w_accept = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last   = (r_state == StShift) && (r_cnt == CntW'(1));

  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) w_acc_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
    // The bit leaving the accumulator MSB is dropped by the truncating cast.
    w_acc_shift = 16'({w_acc_adj, r_opnd[IN_WIDTH-1]});
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_next = StShift;
      end
      StShift: begin
        busy = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = start ? StShift : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opnd     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_opnd     <= bin;
      r_acc      <= '0;
      r_cnt      <= CntW'(IN_WIDTH);
      r_ovf_flag <= (bin > IN_WIDTH'(9999));
    end else if (r_state == StShift) begin
      r_acc  <= w_acc_shift;
      r_opnd <= {r_opnd[IN_WIDTH-2:0], 1'b0};
      r_cnt  <= r_cnt - CntW'(1);
      // Outputs change only here, so the display never sees a partial result.
      if (w_last) begin
        r_digits   <= r_ovf_flag ? 16'h9999 : w_acc_shift;
        r_overflow <= r_ovf_flag;
      end
    end
  end

  assign digit_1  = r_digits[3:0];
  assign digit_2  = r_digits[7:4];
  assign digit_3  = r_digits[11:8];
  assign digit_4  = r_digits[15:12];
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, monitor checks on done.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, overflow;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   n_expected = 0;

  bin_to_bcd_seq #(.IN_WIDTH(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit_1  (digit_1),
    .digit_2  (digit_2),
    .digit_3  (digit_3),
    .digit_4  (digit_4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      n_done++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: digits %h%h%h%h ovf %b, none expected at %0t",
                 digit_4, digit_3, digit_2, digit_1, overflow, $time);
      end else begin
        e = q.pop_front();
        if ({digit_4, digit_3, digit_2, digit_1} !== e.d || overflow !== e.o) begin
          bad++;
          $display("FAIL result: got %h%h%h%h ovf %b expected %h ovf %b at %0t",
                   digit_4, digit_3, digit_2, digit_1, overflow, e.d, e.o, $time);
        end
      end
    end
  end

  // Drive start for one edge; call with time at posedge+1.
  task automatic issue(input logic [13:0] b, input logic [15:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    q.push_back(e);
    n_expected++;
    start = 1'b1;
    bin   = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called in cycle T+1; returns in cycle T+15 (the done cycle). inj_at>0 pulses a stray start.
  task automatic track(input int inj_at);
    for (int c = 1; c <= 14; c++) begin
      chk("busy_in_shift", {31'd0, busy}, 32'd1);
      chk("no_done_in_shift", {31'd0, done}, 32'd0);
      if (c == inj_at) begin
        start = 1'b1;
        bin   = 14'd1111;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    chk("done_latency", {31'd0, done}, 32'd1);
  endtask

  task automatic convert(input logic [13:0] b, input logic [15:0] d, input logic o);
    issue(b, d, o);
    track(0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({name, "_digits"}, {16'd0, digit_4, digit_3, digit_2, digit_1}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset_idle");

    convert(14'd1234, 16'h1234, 1'b0);
    convert(14'd0,    16'h0000, 1'b0);
    convert(14'd9999, 16'h9999, 1'b0);
    convert(14'd10000, 16'h9999, 1'b1);
    convert(14'd16383, 16'h9999, 1'b1);
    convert(14'd42,   16'h0042, 1'b0);
    chk("ovf_cleared_after_42", {31'd0, overflow}, 32'd0);
    chk("digits_held_idle", {16'd0, digit_4, digit_3, digit_2, digit_1}, 32'h0042);

    // Stray start mid-conversion: ignored, one done only.
    issue(14'd5678, 16'h5678, 1'b0);
    track(4);
    @(posedge clk); #1;
    chk("ignored_start_no_restart", {31'd0, busy}, 32'd0);

    // Back-to-back: second start held during the done cycle.
    issue(14'd4321, 16'h4321, 1'b0);
    track(0);
    issue(14'd8765, 16'h8765, 1'b0);
    track(0);
    @(posedge clk); #1;
    chk("b2b_idle_after", {31'd0, busy}, 32'd0);

    // Reset beats a simultaneous start.
    start = 1'b1;
    bin   = 14'd100;
    reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    chk_reset_outputs("reset_over_start");
    @(posedge clk); #1;
    chk("start_dropped", {31'd0, busy}, 32'd0);

    // Abort 2468 with reset sampled at edge T+7.
    start = 1'b1;
    bin   = 14'd2468;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outputs("abort");
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done_digits", {16'd0, digit_4, digit_3, digit_2, digit_1}, 32'd0);
    convert(14'd1357, 16'h1357, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    chk("done_count", n_done, n_expected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
